spimem_wb: RTL and testbench

- WISHBONE 8-bit slave SPI master (mode 0) that drives the on-board SPI memory pins SS_B/SDO/SDI/SCK, which are otherwise tied idle.
- Sits downstream of the WISHBONE intercon as a new slave port `spm`, alongside rs2/ad/tmr/t16.
- Lets CPU firmware read and write the serial flash: one byte per transfer, with chip select under software control.

---
 rtl/spimem_wb.sv | 238 +++++++++++++++++++++++
 tb/tb_spimem_wb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spimem_wb.sv
// spimem_wb: 8-bit WISHBONE slave SPI master (mode 0) for the on-board serial
// memory. The register file is DATA (adr 0), CTRL (adr 1) and STATUS (adr 2).
// Software drives the chip select through CTRL.SSEL. Each write to DATA moves
// one byte, MSB first. The sclk half-period is 2^DIV system clocks.
// Optional macro SPIMEM_IRQ_EN adds a transfer-done interrupt request with an
// acknowledge input. When the macro is undefined, irq_req_o is tied low.
module spimem_wb #(
    parameter int         ADR_W   = 2,
    parameter logic [1:0] DIV_RST = 2'b11
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic [ADR_W-1:0] wb_adr_i,
    input  logic [7:0]       wb_dat_i,
    output logic [7:0]       wb_dat_o,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    output logic             wb_ack_o,
    output logic             irq_req_o,
    input  logic             irq_ack_i,
    output logic             ss_n_o,
    output logic             sclk_o,
    output logic             mosi_o,
    input  logic             miso_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    // Control register
    logic       r_ena;
    logic [1:0] r_div;
    logic       r_ssel;
    logic       r_ss_n;

    // Shift engine
    logic [1:0] r_state;
    logic       r_busy;
    logic       r_sclk;
    logic       r_mosi;
    logic [7:0] r_shreg;
    logic       r_samp;
    logic [2:0] r_bitcnt;
    logic [2:0] r_cnt;
    logic [1:0] r_hdiv;
    logic [7:0] r_rx;

    // Status flags
    logic       r_done;
    logic       r_ovr;

    // Bus decode
    logic       w_wr;
    logic       w_rd;
    logic       w_sel_data;
    logic       w_sel_ctrl;
    logic       w_sel_stat;
    logic       w_wr_data;
    logic       w_wr_ctrl;
    logic       w_rd_data;
    logic       w_start;
    logic       w_ovr_set;
    logic       w_ena_nxt;
    logic       w_ssel_nxt;
    logic [2:0] w_hlast;
    logic       w_tick;
    logic       w_abort;
    logic       w_finish;

    assign w_wr       = wb_stb_i & wb_we_i;
    assign w_rd       = wb_stb_i & ~wb_we_i;
    assign w_sel_data = (wb_adr_i == ADR_W'(0));
    assign w_sel_ctrl = (wb_adr_i == ADR_W'(1));
    assign w_sel_stat = (wb_adr_i == ADR_W'(2));
    assign w_wr_data  = w_wr & w_sel_data;
    assign w_wr_ctrl  = w_wr & w_sel_ctrl;
    assign w_rd_data  = w_rd & w_sel_data;

    assign w_start    = w_wr_data & r_ena & ~r_busy;
    assign w_ovr_set  = w_wr_data & r_ena & r_busy;

    // CTRL as it will be after this edge. The abort check uses this value,
    // so a write that clears ENA stops the engine on the same edge that the
    // chip select deasserts.
    assign w_ena_nxt  = w_wr_ctrl ? wb_dat_i[7] : r_ena;
    assign w_ssel_nxt = w_wr_ctrl ? wb_dat_i[0] : r_ssel;

    // The last count of a half-period. It uses the divider latched at start.
    assign w_hlast    = 3'((4'd1 << r_hdiv) - 4'd1);
    assign w_tick     = (r_cnt == w_hlast);
    assign w_abort    = (r_state != S_IDLE) & ~w_ena_nxt;
    assign w_finish   = (r_state == S_HIGH) & w_tick & (r_bitcnt == 3'd7) & ~w_abort;

    assign wb_ack_o   = wb_stb_i;
    assign ss_n_o     = r_ss_n;
    assign sclk_o     = r_sclk;
    assign mosi_o     = r_mosi;

    // CTRL register and the registered chip select derived from it
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ena  <= 1'b0;
            r_div  <= DIV_RST;
            r_ssel <= 1'b0;
            r_ss_n <= 1'b1;
        end else begin
            if (w_wr_ctrl) begin
                r_ena  <= wb_dat_i[7];
                r_div  <= wb_dat_i[2:1];
                r_ssel <= wb_dat_i[0];
            end
            r_ss_n <= ~(w_ssel_nxt & w_ena_nxt);
        end
    end

    // Bit engine: IDLE -> LOW -> HIGH, eight times, then back to IDLE
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_shreg  <= '0;
            r_samp   <= 1'b0;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_hdiv   <= DIV_RST;
            r_rx     <= '0;
        end else if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_LOW;
                        r_busy   <= 1'b1;
                        r_shreg  <= wb_dat_i;
                        r_mosi   <= wb_dat_i[7];
                        r_bitcnt <= '0;
                        r_cnt    <= '0;
                        r_hdiv   <= r_div;
                    end
                end
                S_LOW: begin
                    if (w_tick) begin
                        r_state <= S_HIGH;
                        r_sclk  <= 1'b1;
                        r_samp  <= miso_i;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_HIGH: begin
                    if (w_tick) begin
                        r_sclk <= 1'b0;
                        r_cnt  <= '0;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_IDLE;
                            r_rx    <= {r_shreg[6:0], r_samp};
                            r_busy  <= 1'b0;
                            r_mosi  <= 1'b0;
                        end else begin
                            r_state  <= S_LOW;
                            r_shreg  <= {r_shreg[6:0], r_samp};
                            r_mosi   <= r_shreg[6];
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_sclk  <= 1'b0;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

    // DONE and OVR flags. A completing transfer wins over a DATA read in the same cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_finish)
                r_done <= 1'b1;
            else if (w_start || w_rd_data)
                r_done <= 1'b0;

            if (w_ovr_set)
                r_ovr <= 1'b1;
            else if (w_rd_data)
                r_ovr <= 1'b0;
        end
    end

`ifdef SPIMEM_IRQ_EN
    logic r_irq;

    // Interrupt request. It rises with DONE and is dropped by ack or a DATA read. The set wins.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)
            r_irq <= 1'b0;
        else if (w_finish)
            r_irq <= 1'b1;
        else if (irq_ack_i || w_rd_data)
            r_irq <= 1'b0;
    end

    assign irq_req_o = r_irq;
`else
    logic w_unused_irq_ack;

    assign w_unused_irq_ack = irq_ack_i;
    assign irq_req_o        = 1'b0;
`endif

    // Read mux, combinational from the address
    always_comb begin
        wb_dat_o = '0;
        if (w_sel_data)
            wb_dat_o = r_rx;
        else if (w_sel_ctrl)
            wb_dat_o = {r_ena, 4'b0000, r_div, r_ssel};
        else if (w_sel_stat)
            wb_dat_o = {5'b00000, r_ovr, r_done, r_busy};
    end

endmodule

// File: tb/tb_spimem_wb.sv
// Testbench for spimem_wb. It uses table-driven register and transfer vectors,
// plus hand-written sequences for the divider, overrun, set-wins, ENA=0, abort
// and mid-transfer reset cases. A small slave model shifts out a byte on MISO.
module tb_spimem_wb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] adr = '0;
    logic [7:0] dat_i = '0;
    logic [7:0] dat_o;
    logic       we = 1'b0;
    logic       stb = 1'b0;
    logic       ack;
    logic       irq_req;
    logic       irq_ack = 1'b0;
    logic       ss_n;
    logic       sclk;
    logic       mosi;
    logic       miso;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    spimem_wb #(.ADR_W(2), .DIV_RST(2'b11)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_i),
        .wb_dat_o   (dat_o),
        .wb_we_i    (we),
        .wb_stb_i   (stb),
        .wb_ack_o   (ack),
        .irq_req_o  (irq_req),
        .irq_ack_i  (irq_ack),
        .ss_n_o     (ss_n),
        .sclk_o     (sclk),
        .mosi_o     (mosi),
        .miso_i     (miso)
    );

    always @(posedge clk) cyc++;

    // SPI observation: rising/falling timestamps and MOSI captured on each rise
    int         nr = 0;
    int         nf = 0;
    int         rise_cyc [256];
    int         fall_cyc [256];
    logic [7:0] mosi_cap = '0;
    logic       irq_seen = 1'b0;

    always @(posedge sclk) begin
        rise_cyc[nr % 256] = cyc;
        mosi_cap = {mosi_cap[6:0], mosi};
        nr++;
    end

    always @(negedge sclk) begin
        fall_cyc[nf % 256] = cyc;
        nf++;
    end

    always @(posedge clk) if (irq_req === 1'b1) irq_seen = 1'b1;

    // Mode-0 slave: MSB presented before the first rise, next bit after each fall
    logic [7:0] s_val = '0;
    int         s_base = 0;

    always_comb begin
        int d;
        d = nf - s_base;
        miso = 1'b0;
        if (d >= 0 && d < 8) miso = s_val[3'(7 - d)];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
        adr = a; dat_i = d; we = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [7:0] d);
        adr = a; we = 1'b0; stb = 1'b1;
        #1 d = dat_o;
        @(posedge clk); #1;
        stb = 1'b0;
    endtask

    // Count edges while STATUS.BUSY reads 1. Optionally perform one bus
    // cycle (mid_adr/mid_we/mid_dat) in iteration mid_k.
    task automatic measure(input int mid_k, input logic [1:0] mid_adr, input logic mid_we,
                           input logic [7:0] mid_dat, output int n);
        n = 0;
        adr = 2'd2; we = 1'b0; stb = 1'b1;
        #1;
        while (dat_o[0] === 1'b1 && n < 2000) begin
            if (n == mid_k) begin
                adr = mid_adr; we = mid_we; dat_i = mid_dat;
            end
            @(posedge clk); #1;
            adr = 2'd2; we = 1'b0; stb = 1'b1;
            #1;
            n++;
        end
        stb = 1'b0;
    endtask

    task automatic start_xfer(input logic [7:0] ctrl, input logic [7:0] tx, input logic [7:0] sv,
                              output int wcyc, output int rbase, output int fbase);
        wb_write(2'd1, ctrl);
        s_val = sv;
        s_base = nf;
        rbase = nr;
        fbase = nf;
        wb_write(2'd0, tx);
        wcyc = cyc;
    endtask

    function automatic logic timing_ok(input int wcyc, input int rbase, input int fbase, input int h);
        logic ok;
        ok = (nr - rbase == 8) && (nf - fbase == 8);
        for (int i = 0; i < 8; i++) begin
            if (rise_cyc[(rbase + i) % 256] != wcyc + h + 2 * h * i) ok = 1'b0;
            if (fall_cyc[(fbase + i) % 256] != wcyc + 2 * h + 2 * h * i) ok = 1'b0;
        end
        return ok;
    endfunction

    typedef struct {
        logic [7:0] wr;
        logic [7:0] rd;
        logic       ss_n;
    } ctrl_vec_t;

    typedef struct {
        logic [7:0] ctrl;
        logic [7:0] tx;
        logic [7:0] sval;
        int         h;
    } xfer_vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_vec_t  cv [5];
        xfer_vec_t  xv [4];
        logic [7:0] v;
        int         n, wcyc, rbase, fbase;

        cv[0] = '{8'h81, 8'h81, 1'b0};
        cv[1] = '{8'hFF, 8'h87, 1'b0};
        cv[2] = '{8'h7E, 8'h06, 1'b1};
        cv[3] = '{8'h01, 8'h01, 1'b1};
        cv[4] = '{8'h80, 8'h80, 1'b1};

        xv[0] = '{8'h81, 8'hA5, 8'h3C, 1};
        xv[1] = '{8'h83, 8'h00, 8'hFF, 2};
        xv[2] = '{8'h85, 8'hFF, 8'h00, 4};
        xv[3] = '{8'h81, 8'h5A, 8'hC3, 1};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", 32'(ss_n), 32'h1);
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        chk("rst_irq", 32'(irq_req), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(2'd1, v); chk("rst_ctrl", 32'(v), 32'h06);
        wb_read(2'd0, v); chk("rst_data", 32'(v), 32'h00);
        wb_read(2'd2, v); chk("rst_status", 32'(v), 32'h00);
        stb = 1'b1; #1;
        chk("ack_follows_stb", 32'(ack), 32'h1);
        stb = 1'b0; #1;
        chk("ack_low", 32'(ack), 32'h0);

        // CTRL register table
        for (int i = 0; i < 5; i++) begin
            wb_write(2'd1, cv[i].wr);
            wb_read(2'd1, v);
            chk($sformatf("ctrl_rd[%0d]", i), 32'(v), 32'(cv[i].rd));
            chk($sformatf("ctrl_ss_n[%0d]", i), 32'(ss_n), 32'(cv[i].ss_n));
        end
        wb_write(2'd3, 8'hFF);
        wb_read(2'd3, v); chk("adr3_rd", 32'(v), 32'h00);
        wb_read(2'd1, v); chk("adr3_no_effect", 32'(v), 32'h80);

        // Transfer table
        for (int i = 0; i < 4; i++) begin
            start_xfer(xv[i].ctrl, xv[i].tx, xv[i].sval, wcyc, rbase, fbase);
            chk($sformatf("x%0d_ss_n", i), 32'(ss_n), 32'h0);
            measure(-1, 2'd0, 1'b0, 8'h00, n);
            chk($sformatf("x%0d_busy_cycles", i), 32'(n), 32'(16 * xv[i].h));
            chk($sformatf("x%0d_sclk_timing", i), 32'(timing_ok(wcyc, rbase, fbase, xv[i].h)), 32'h1);
            chk($sformatf("x%0d_mosi", i), 32'(mosi_cap), 32'(xv[i].tx));
`ifdef SPIMEM_IRQ_EN
            chk($sformatf("x%0d_irq_set", i), 32'(irq_req), 32'h1);
            if (i == 0) begin
                irq_ack = 1'b1;
                @(posedge clk); #1;
                irq_ack = 1'b0;
                chk("irq_ack_clear", 32'(irq_req), 32'h0);
            end
`endif
            wb_read(2'd2, v); chk($sformatf("x%0d_status_done", i), 32'(v), 32'h02);
            wb_read(2'd0, v); chk($sformatf("x%0d_rx", i), 32'(v), 32'(xv[i].sval));
            wb_read(2'd2, v); chk($sformatf("x%0d_status_clr", i), 32'(v), 32'h00);
`ifdef SPIMEM_IRQ_EN
            chk($sformatf("x%0d_irq_clr", i), 32'(irq_req), 32'h0);
`endif
        end

        // Divider 3 with a CTRL rewrite mid-transfer. The timing must not change.
        start_xfer(8'h87, 8'hC9, 8'h1E, wcyc, rbase, fbase);
        measure(20, 2'd1, 1'b1, 8'h81, n);
        chk("div_busy_cycles", 32'(n), 32'd128);
        chk("div_sclk_timing", 32'(timing_ok(wcyc, rbase, fbase, 8)), 32'h1);
        chk("div_mosi", 32'(mosi_cap), 32'hC9);
        wb_read(2'd0, v); chk("div_rx", 32'(v), 32'h1E);
        wb_read(2'd1, v); chk("div_ctrl_rewritten", 32'(v), 32'h81);

        // Overrun: a DATA write while busy sets OVR and leaves the byte alone
        start_xfer(8'h81, 8'h11, 8'h96, wcyc, rbase, fbase);
        measure(3, 2'd0, 1'b1, 8'h22, n);
        chk("ovr_busy_cycles", 32'(n), 32'd16);
        chk("ovr_mosi", 32'(mosi_cap), 32'h11);
        wb_read(2'd2, v); chk("ovr_status", 32'(v), 32'h06);
        wb_read(2'd0, v); chk("ovr_rx", 32'(v), 32'h96);
        wb_read(2'd2, v); chk("ovr_status_clr", 32'(v), 32'h00);

        // A DATA read on the completion edge: the DONE set wins
        start_xfer(8'h81, 8'h4B, 8'h69, wcyc, rbase, fbase);
        measure(15, 2'd0, 1'b0, 8'h00, n);
        chk("setwin_busy_cycles", 32'(n), 32'd16);
`ifdef SPIMEM_IRQ_EN
        chk("setwin_irq", 32'(irq_req), 32'h1);
`endif
        wb_read(2'd2, v); chk("setwin_status", 32'(v), 32'h02);
        wb_read(2'd0, v); chk("setwin_rx", 32'(v), 32'h69);

        // DATA write with ENA=0 is ignored and does not set OVR
        wb_write(2'd1, 8'h01);
        chk("ena0_ss_n", 32'(ss_n), 32'h1);
        rbase = nr;
        wb_write(2'd0, 8'h77);
        repeat (4) @(posedge clk);
        #1;
        wb_read(2'd2, v); chk("ena0_status", 32'(v), 32'h00);
        chk("ena0_no_sclk", 32'(nr - rbase), 32'h0);

        // Abort by clearing ENA on cycle 5 of a transfer
        start_xfer(8'h87, 8'hB3, 8'hAA, wcyc, rbase, fbase);
        chk("abort_mosi_pre", 32'(mosi), 32'h1);
        measure(5, 2'd1, 1'b1, 8'h00, n);
        chk("abort_busy_cycles", 32'(n), 32'd6);
        chk("abort_sclk", 32'(sclk), 32'h0);
        chk("abort_mosi", 32'(mosi), 32'h0);
        chk("abort_ss_n", 32'(ss_n), 32'h1);
        wb_read(2'd2, v); chk("abort_status", 32'(v), 32'h00);
        wb_read(2'd0, v); chk("abort_rx_kept", 32'(v), 32'h69);

        // Asynchronous reset in the middle of a HIGH phase
        start_xfer(8'h87, 8'hFF, 8'h00, wcyc, rbase, fbase);
        repeat (10) @(posedge clk);
        #3;
        chk("mrst_pre_sclk", 32'(sclk), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mrst_ss_n", 32'(ss_n), 32'h1);
        chk("mrst_sclk", 32'(sclk), 32'h0);
        chk("mrst_mosi", 32'(mosi), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_read(2'd1, v); chk("mrst_ctrl", 32'(v), 32'h06);
        wb_read(2'd2, v); chk("mrst_status", 32'(v), 32'h00);
        wb_read(2'd0, v); chk("mrst_rx", 32'(v), 32'h00);

`ifndef SPIMEM_IRQ_EN
        chk("irq_never_set", 32'(irq_seen), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
